// File: rtl/alu_seq_ctrl.sv
// Operand-entry / arithmetic sequencer for the 4-bit calculator: debounced enter key,
// add/sub/neg in one cycle, shift-add multiply over four cycles.
// state  | meaning
// LOAD_A | waiting for press to latch A (clears R/ovf)
// LOAD_B | waiting for press to latch B and OP
// EXEC   | single-cycle ops complete; mul operands prepared
// MUL    | one |B| bit per cycle, result written on the 4th
// SHOW   | hold results until press
module alu_seq_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic [3:0] SW,
  input  logic [1:0] OP,
  input  logic       KEY_N,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [3:0] R,
  output logic       ovf,
  output logic       BUSY,
  output logic [2:0] STATE
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    LOAD_A = 3'b000,
    LOAD_B = 3'b001,
    EXEC   = 3'b010,
    MUL    = 3'b011,
    SHOW   = 3'b100
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_stable;
  logic                   r_press;
  logic                   w_key_s;

  state_t     r_state;
  logic [3:0] r_a, r_b, r_r;
  logic       r_ovf;
  logic [1:0] r_op;
  logic [3:0] r_mag_a, r_mag_b;
  logic       r_sign;
  logic [7:0] r_acc;
  logic [1:0] r_it;

  logic [3:0] w_add, w_sub, w_neg, w_abs_a, w_abs_b;
  logic [7:0] w_pp, w_acc_nxt, w_prod;
  logic       w_prod_ovf;

  assign w_key_s = r_sync[SYNC_STAGES-1];

  // The count only advances while the synchronized key disagrees with the accepted
  // level, so any return to the old level (bounce or short glitch) restarts it.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_sync   <= '1;
      r_cnt    <= '0;
      r_stable <= 1'b1;
      r_press  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], KEY_N};
      r_press <= 1'b0;
      if (w_key_s == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_cnt    <= '0;
        r_stable <= w_key_s;
        r_press  <= ~w_key_s;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign w_add   = r_a + r_b;
  assign w_sub   = r_a - r_b;
  assign w_neg   = 4'd0 - r_a;
  assign w_abs_a = r_a[3] ? 4'd0 - r_a : r_a;
  assign w_abs_b = r_b[3] ? 4'd0 - r_b : r_b;

  assign w_pp       = r_mag_b[r_it] ? ({4'd0, r_mag_a} << r_it) : 8'd0;
  assign w_acc_nxt  = r_acc + w_pp;
  assign w_prod     = r_sign ? 8'd0 - w_acc_nxt : w_acc_nxt;
  // Product fits in 4 signed bits only when bits 7..3 are all equal.
  assign w_prod_ovf = ~((&w_prod[7:3]) | ~(|w_prod[7:3]));

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state <= LOAD_A;
      r_a     <= '0;
      r_b     <= '0;
      r_r     <= '0;
      r_ovf   <= 1'b0;
      r_op    <= '0;
      r_mag_a <= '0;
      r_mag_b <= '0;
      r_sign  <= 1'b0;
      r_acc   <= '0;
      r_it    <= '0;
    end else begin
      case (r_state)
        LOAD_A: if (r_press) begin
          r_a     <= SW;
          r_r     <= '0;
          r_ovf   <= 1'b0;
          r_state <= LOAD_B;
        end
        LOAD_B: if (r_press) begin
          r_b     <= SW;
          r_op    <= OP;
          r_state <= EXEC;
        end
        EXEC: begin
          r_state <= SHOW;
          case (r_op)
            2'b00: begin
              r_r   <= w_add;
              r_ovf <= (r_a[3] == r_b[3]) && (w_add[3] != r_a[3]);
            end
            2'b01: begin
              r_r   <= w_sub;
              r_ovf <= (r_a[3] != r_b[3]) && (w_sub[3] != r_a[3]);
            end
            2'b11: begin
              r_r   <= w_neg;
              r_ovf <= (r_a == 4'b1000);
            end
            default: begin
              r_mag_a <= w_abs_a;
              r_mag_b <= w_abs_b;
              r_sign  <= r_a[3] ^ r_b[3];
              r_acc   <= '0;
              r_it    <= '0;
              r_state <= MUL;
            end
          endcase
        end
        MUL: begin
          r_acc <= w_acc_nxt;
          r_it  <= r_it + 1'b1;
          if (r_it == 2'd3) begin
            r_r     <= w_prod[3:0];
            r_ovf   <= w_prod_ovf;
            r_state <= SHOW;
          end
        end
        SHOW: if (r_press) r_state <= LOAD_A;
        default: r_state <= LOAD_A;
      endcase
    end
  end

  assign A     = r_a;
  assign B     = r_b;
  assign R     = r_r;
  assign ovf   = r_ovf;
  assign BUSY  = (r_state == EXEC) || (r_state == MUL);
  assign STATE = r_state;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: each operation from the test plan with hand-computed
// results, BUSY length, key glitch rejection, held-press drop and asynchronous reset.
module tb_alu_seq_ctrl;
  logic       CLK = 1'b0;
  logic       RESETn = 1'b0;
  logic [3:0] SW = 4'd0;
  logic [1:0] OP = 2'd0;
  logic       KEY_N = 1'b1;
  logic [3:0] A, B, R;
  logic       ovf, BUSY;
  logic [2:0] STATE;

  int errors = 0;
  int checks = 0;

  alu_seq_ctrl #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .CLK(CLK), .RESETn(RESETn), .SW(SW), .OP(OP), .KEY_N(KEY_N),
    .A(A), .B(B), .R(R), .ovf(ovf), .BUSY(BUSY), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_change(input logic [2:0] from);
    for (int i = 0; i < 40 && STATE == from; i++) @(negedge CLK);
  endtask

  task automatic do_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] op, input logic [3:0] er, input logic eovf,
                       input int ebusy);
    int busy;
    @(negedge CLK);
    SW = a; OP = op; KEY_N = 1'b0;
    wait_change(3'b000);
    SW = ~a;
    chk({tag, " A latched"}, A, a);
    chk({tag, " R cleared"}, R, 4'd0);
    chk({tag, " ovf cleared"}, ovf, 1'b0);
    chk({tag, " state LOAD_B"}, STATE, 3'b001);
    KEY_N = 1'b1;
    repeat (12) @(negedge CLK);
    SW = b; KEY_N = 1'b0;
    wait_change(3'b001);
    chk({tag, " state EXEC"}, STATE, 3'b010);
    OP = ~op; SW = ~b;
    busy = 0;
    for (int i = 0; i < 20 && BUSY; i++) begin
      busy++;
      @(negedge CLK);
    end
    chk({tag, " busy cycles"}, busy[7:0], ebusy[7:0]);
    chk({tag, " state SHOW"}, STATE, 3'b100);
    chk({tag, " R"}, R, er);
    chk({tag, " ovf"}, ovf, eovf);
    chk({tag, " A hold"}, A, a);
    chk({tag, " B"}, B, b);
    repeat (15) @(negedge CLK);
    chk({tag, " held press ignored"}, STATE, 3'b100);
    KEY_N = 1'b1;
    repeat (12) @(negedge CLK);
    KEY_N = 1'b0;
    wait_change(3'b100);
    chk({tag, " back to LOAD_A"}, STATE, 3'b000);
    chk({tag, " R held in LOAD_A"}, R, er);
    KEY_N = 1'b1;
    repeat (12) @(negedge CLK);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk("reset A", A, 4'd0);
    chk("reset R", R, 4'd0);
    chk("reset BUSY", BUSY, 1'b0);
    chk("reset STATE", STATE, 3'b000);
    RESETn = 1'b1;
    repeat (3) @(negedge CLK);

    KEY_N = 1'b0;
    repeat (2) @(negedge CLK);
    KEY_N = 1'b1;
    repeat (15) @(negedge CLK);
    chk("glitch rejected", STATE, 3'b000);

    do_op("add1", 4'b0011, 4'b0100, 2'b00, 4'b0111, 1'b0, 1);
    do_op("add2", 4'b0101, 4'b0100, 2'b00, 4'b1001, 1'b1, 1);
    do_op("sub1", 4'b1000, 4'b0001, 2'b01, 4'b0111, 1'b1, 1);
    do_op("sub2", 4'b0010, 4'b0101, 2'b01, 4'b1101, 1'b0, 1);
    do_op("mul1", 4'b1101, 4'b0010, 2'b10, 4'b1010, 1'b0, 5);
    do_op("mul2", 4'b0011, 4'b0011, 2'b10, 4'b1001, 1'b1, 5);
    do_op("mul3", 4'b1000, 4'b1111, 2'b10, 4'b1000, 1'b1, 5);
    do_op("neg1", 4'b0101, 4'b0000, 2'b11, 4'b1011, 1'b0, 1);
    do_op("neg2", 4'b1000, 4'b0000, 2'b11, 4'b1000, 1'b1, 1);
    do_op("neg3", 4'b0000, 4'b0000, 2'b11, 4'b0000, 1'b0, 1);

    // Abort a multiply with reset between clock edges.
    @(negedge CLK);
    SW = 4'b0011; OP = 2'b10; KEY_N = 1'b0;
    wait_change(3'b000);
    KEY_N = 1'b1;
    repeat (12) @(negedge CLK);
    SW = 4'b0011; KEY_N = 1'b0;
    wait_change(3'b001);
    @(negedge CLK);
    chk("rst: in MUL", STATE, 3'b011);
    #2 RESETn = 1'b0;
    #1;
    chk("rst: A", A, 4'd0);
    chk("rst: B", B, 4'd0);
    chk("rst: R", R, 4'd0);
    chk("rst: ovf", ovf, 1'b0);
    chk("rst: BUSY", BUSY, 1'b0);
    chk("rst: STATE", STATE, 3'b000);
    KEY_N = 1'b1;
    @(negedge CLK);
    RESETn = 1'b1;
    repeat (5) @(negedge CLK);
    do_op("post-rst mul", 4'b0010, 4'b1110, 2'b10, 4'b1100, 1'b0, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
